dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester (CPU / loader) data-memory arbiter with a
//               round-robin pick, loader lock and registered memory strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ldr_mode,
    input  logic              cpu_req,
    input  logic              ldr_req,
    input  logic              cpu_we,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              cpu_ack,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    logic   r_we;
    logic   r_gnt;   // granted requester: 0 = CPU, 1 = loader
    logic   r_last;  // last granted requester, same encoding

    logic w_cpu_elig;
    logic w_ldr_elig;
    logic w_pick_ldr;
    logic w_sel_we;

    assign w_cpu_elig = cpu_req & ~ldr_mode;
    assign w_ldr_elig = ldr_req;
    // Loader wins when it is the only candidate or when the CPU went last.
    assign w_pick_ldr = w_ldr_elig & (~w_cpu_elig | ~r_last);
    assign w_sel_we   = w_pick_ldr ? ldr_we : cpu_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_elig || w_ldr_elig) begin
                        r_we      <= w_sel_we;
                        r_gnt     <= w_pick_ldr;
                        r_last    <= w_pick_ldr;
                        mem_addr  <= w_pick_ldr ? ldr_addr  : cpu_addr;
                        mem_wdata <= w_pick_ldr ? ldr_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= w_sel_we;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        cpu_ack <= ~r_gnt;
                        ldr_ack <= r_gnt;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (r_gnt) begin
                        ldr_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= mem_rdata;
                    end
                    cpu_ack <= ~r_gnt;
                    ldr_ack <= r_gnt;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
